// File: rtl/rsz_pkg.sv
// Shared defaults and the accumulator type for the block-resize datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rsz_pkg;

    localparam int DEF_IDX_W = 10;
    localparam int DEF_PXL_W = 8;
    localparam int DEF_SUM_W = 24;
    localparam int DEF_CNT_W = 16;

    // One block accumulator at the default accumulator width
    typedef logic [DEF_SUM_W-1:0] acc_t;

endpackage

// File: rtl/onehot_mux_2d.sv
// OR-based selector over an NY x NX grid of W-bit entries, picked by an X mask and a Y mask.
// Latency: combinational.
// Backpressure: none; an all-zero mask yields 0, several selected entries are ORed together.
module onehot_mux_2d #(
    parameter int W  = 8,
    parameter int NX = 4,
    parameter int NY = 4
) (
    input  logic [NY*NX*W-1:0] dataIn,
    input  logic [NX-1:0]      xMsk,
    input  logic [NY-1:0]      yMsk,
    output logic [W-1:0]       dataOut
);

    // OR together every entry whose row and column are both selected
    always_comb begin
        dataOut = '0;
        for (int y = 0; y < NY; y++) begin
            for (int x = 0; x < NX; x++) begin
                if (xMsk[x] && yMsk[y]) begin
                    dataOut = dataOut | dataIn[(y*NX+x)*W +: W];
                end
            end
        end
    end

endmodule

// File: rtl/rsz_blk_accum.sv
// Per-block pixel accumulator for image downsizing; define RSZ_MAX_POOL_EN for max pooling instead of sums.
// Latency: accumulators/counters/flags update on the next Clk edge; CompData/FlushData/BlkIsEnough are combinational.
// Backpressure: none, a pixel is accepted every cycle PxlVld is high.
module rsz_blk_accum
    import rsz_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int RSZ_W = 4,
    parameter int RSZ_H = 4,
    parameter int PXL_W = DEF_PXL_W,
    parameter int SUM_W = DEF_SUM_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [IDX_W-1:0]       ImgWidth,
    input  logic [IDX_W-1:0]       ImgHeight,
    input  logic [PXL_W-1:0]       PxlData,
    input  logic [IDX_W-1:0]       PxlX,
    input  logic [IDX_W-1:0]       PxlY,
    input  logic                   PxlVld,
    input  logic [CNT_W-1:0]       BlkSz,
    output logic [RSZ_H*RSZ_W-1:0] BlkIsEnough,
    input  logic [RSZ_W-1:0]       CompXMsk,
    input  logic [RSZ_H-1:0]       CompYMsk,
    input  logic                   CompEn,
    output logic [SUM_W-1:0]       CompData,
    input  logic [PXL_W-1:0]       CeData,
    input  logic [RSZ_W-1:0]       CeXMsk,
    input  logic [RSZ_H-1:0]       CeYMsk,
    input  logic                   CeVld,
    output logic [RSZ_H*RSZ_W-1:0] BlkIsExec,
    input  logic [RSZ_W-1:0]       FlushXMsk,
    input  logic [RSZ_H-1:0]       FlushYMsk,
    input  logic                   FlushVld,
    output logic [PXL_W-1:0]       FlushData
);

    localparam int RSZ_WL = $clog2(RSZ_W);
    localparam int RSZ_HL = $clog2(RSZ_H);
    localparam int NBLK   = RSZ_H * RSZ_W;
    // Room for RSZ_W*ImgWidth before the divide by RSZ_W
    localparam int SX_W   = IDX_W + RSZ_WL;
    localparam int SY_W   = IDX_W + RSZ_HL;

    logic [SX_W-1:0]  sumX  [RSZ_W+1];
    logic [SY_W-1:0]  sumY  [RSZ_H+1];
    logic [IDX_W-1:0] baseX [RSZ_W+1];
    logic [IDX_W-1:0] baseY [RSZ_H+1];
    logic [RSZ_W-1:0] colHit;
    logic [RSZ_H-1:0] rowHit;

    logic [NBLK-1:0]  pxlHit;
    logic [NBLK-1:0]  ceHit;
    logic [NBLK-1:0]  clrHit;
    logic [NBLK-1:0]  flushHit;

    logic [SUM_W-1:0] acc [NBLK];
    logic [CNT_W-1:0] cnt [NBLK];
    logic [NBLK-1:0]  execFlag;

    logic [SUM_W-1:0] pxlExt;
    logic [SUM_W-1:0] ceExt;
    logic [NBLK*SUM_W-1:0] accFlat;
    logic [NBLK*PXL_W-1:0] accLowFlat;

    assign pxlExt = SUM_W'(PxlData);
    assign ceExt  = SUM_W'(CeData);

    // Block boundaries: u*ImgWidth/RSZ_W built by repeated addition, no multiplier
    always_comb begin
        sumX[0] = '0;
        for (int u = 1; u <= RSZ_W; u++) begin
            sumX[u] = sumX[u-1] + SX_W'(ImgWidth);
        end
        sumY[0] = '0;
        for (int v = 1; v <= RSZ_H; v++) begin
            sumY[v] = sumY[v-1] + SY_W'(ImgHeight);
        end
        for (int u = 0; u <= RSZ_W; u++) begin
            baseX[u] = IDX_W'(sumX[u] >> RSZ_WL);
        end
        for (int v = 0; v <= RSZ_H; v++) begin
            baseY[v] = IDX_W'(sumY[v] >> RSZ_HL);
        end
    end

    // Half-open column/row match so a pixel lands in at most one block
    always_comb begin
        for (int u = 0; u < RSZ_W; u++) begin
            colHit[u] = (PxlX >= baseX[u]) && (PxlX < baseX[u+1]);
        end
        for (int v = 0; v < RSZ_H; v++) begin
            rowHit[v] = (PxlY >= baseY[v]) && (PxlY < baseY[v+1]);
        end
    end

    // Per-block event decode from the pixel match and the three mask pairs
    always_comb begin
        for (int y = 0; y < RSZ_H; y++) begin
            for (int x = 0; x < RSZ_W; x++) begin
                pxlHit[y*RSZ_W+x]   = PxlVld   && colHit[x]    && rowHit[y];
                ceHit[y*RSZ_W+x]    = CeVld    && CeXMsk[x]    && CeYMsk[y];
                clrHit[y*RSZ_W+x]   = CompEn   && CompXMsk[x]  && CompYMsk[y];
                flushHit[y*RSZ_W+x] = FlushVld && FlushXMsk[x] && FlushYMsk[y];
            end
        end
    end

    // Block state: write-back beats a pixel, counter clear beats a pixel, set/clear of exec cancel out
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NBLK; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            execFlag <= '0;
        end else begin
            for (int i = 0; i < NBLK; i++) begin
                if (ceHit[i]) begin
                    acc[i] <= ceExt;
                end else if (pxlHit[i]) begin
`ifdef RSZ_MAX_POOL_EN
                    acc[i] <= (acc[i] > pxlExt) ? acc[i] : pxlExt;
`else
                    acc[i] <= acc[i] + pxlExt;
`endif
                end

                if (clrHit[i]) begin
                    cnt[i] <= '0;
                end else if (pxlHit[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end

                if (ceHit[i] && !flushHit[i]) begin
                    execFlag[i] <= 1'b1;
                end else if (flushHit[i] && !ceHit[i]) begin
                    execFlag[i] <= 1'b0;
                end
            end
        end
    end

    // Completion flags and flattened accumulator views for the selectors
    always_comb begin
        for (int i = 0; i < NBLK; i++) begin
            BlkIsEnough[i]                 = (cnt[i] == BlkSz);
            accFlat[i*SUM_W +: SUM_W]      = acc[i];
            accLowFlat[i*PXL_W +: PXL_W]   = acc[i][PXL_W-1:0];
        end
    end

    assign BlkIsExec = execFlag;

    onehot_mux_2d #(
        .W  (SUM_W),
        .NX (RSZ_W),
        .NY (RSZ_H)
    ) u_compMux (
        .dataIn  (accFlat),
        .xMsk    (CompXMsk),
        .yMsk    (CompYMsk),
        .dataOut (CompData)
    );

    // Only the low pixel bits are flushed, so select on the truncated view
    onehot_mux_2d #(
        .W  (PXL_W),
        .NX (RSZ_W),
        .NY (RSZ_H)
    ) u_flushMux (
        .dataIn  (accLowFlat),
        .xMsk    (FlushXMsk),
        .yMsk    (FlushYMsk),
        .dataOut (FlushData)
    );

endmodule

// File: tb/tb_rsz_blk_accum.sv
// Bench for rsz_blk_accum at default parameters; a reference model feeds an expectation queue.
// Latency: model updated alongside each driven clock edge, outputs sampled after the edge.
// Backpressure: none to model.
module tb_rsz_blk_accum;
    import rsz_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  ImgWidth, ImgHeight, PxlX, PxlY;
    logic [7:0]  PxlData, CeData;
    logic        PxlVld, CeVld, CompEn, FlushVld;
    logic [15:0] BlkSz;
    logic [15:0] BlkIsEnough, BlkIsExec;
    logic [3:0]  CompXMsk, CompYMsk, CeXMsk, CeYMsk, FlushXMsk, FlushYMsk;
    logic [23:0] CompData;
    logic [7:0]  FlushData;

    rsz_blk_accum dut (
        .Clk(Clk), .Reset(Reset), .ImgWidth(ImgWidth), .ImgHeight(ImgHeight),
        .PxlData(PxlData), .PxlX(PxlX), .PxlY(PxlY), .PxlVld(PxlVld), .BlkSz(BlkSz),
        .BlkIsEnough(BlkIsEnough), .CompXMsk(CompXMsk), .CompYMsk(CompYMsk), .CompEn(CompEn),
        .CompData(CompData), .CeData(CeData), .CeXMsk(CeXMsk), .CeYMsk(CeYMsk), .CeVld(CeVld),
        .BlkIsExec(BlkIsExec), .FlushXMsk(FlushXMsk), .FlushYMsk(FlushYMsk), .FlushVld(FlushVld),
        .FlushData(FlushData)
    );

    always #5 Clk = ~Clk;

    int nChecks = 0;
    int nFail   = 0;
    logic [31:0] sbQ[$];

    acc_t        mAcc [16];
    logic [15:0] mCnt [16];
    logic [15:0] mExec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Block index along one axis, using a direct multiply-and-divide bound
    function automatic int colOf(input int p, input int dim);
        for (int u = 0; u < 4; u++) begin
            if (p >= (u*dim)/4 && p < ((u+1)*dim)/4) return u;
        end
        return -1;
    endfunction

    task automatic modelTick();
        int cx, cy, i;
        bit ph, ch, clr, fh;
        if (Reset) begin
            for (int k = 0; k < 16; k++) begin mAcc[k] = '0; mCnt[k] = '0; end
            mExec = '0;
            return;
        end
        cx = colOf(int'(PxlX), int'(ImgWidth));
        cy = colOf(int'(PxlY), int'(ImgHeight));
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                i   = y*4 + x;
                ph  = PxlVld && cx == x && cy == y;
                ch  = CeVld && CeXMsk[x] && CeYMsk[y];
                clr = CompEn && CompXMsk[x] && CompYMsk[y];
                fh  = FlushVld && FlushXMsk[x] && FlushYMsk[y];
                if (ch) mAcc[i] = acc_t'(CeData);
                else if (ph) begin
`ifdef RSZ_MAX_POOL_EN
                    if (acc_t'(PxlData) > mAcc[i]) mAcc[i] = acc_t'(PxlData);
`else
                    mAcc[i] = mAcc[i] + acc_t'(PxlData);
`endif
                end
                if (clr) mCnt[i] = '0;
                else if (ph) mCnt[i] = mCnt[i] + 16'd1;
                if (ch && !fh) mExec[i] = 1'b1;
                else if (fh && !ch) mExec[i] = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] modelSel(input logic [3:0] xm, input logic [3:0] ym);
        logic [31:0] r = '0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                if (xm[x] && ym[y]) r = r | 32'(mAcc[y*4+x]);
        return r;
    endfunction

    function automatic logic [15:0] modelEnough();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = (mCnt[i] == BlkSz);
        return r;
    endfunction

    task automatic step();
        modelTick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        PxlVld = 0; CeVld = 0; CompEn = 0; FlushVld = 0;
    endtask

    task automatic doReset();
        Reset = 1; step(); Reset = 0;
    endtask

    task automatic pixel(input int x, input int y, input int d);
        PxlX = 10'(x); PxlY = 10'(y); PxlData = 8'(d); PxlVld = 1;
        step();
        PxlVld = 0;
    endtask

    task automatic readCmp(input string tag, input logic [3:0] xm, input logic [3:0] ym);
        CompXMsk = xm; CompYMsk = ym;
        sbQ.push_back(modelSel(xm, ym));
        #2;
        chk(tag, 32'(CompData), sbQ.pop_front());
        step();
    endtask

    task automatic readCmpK(input string tag, input logic [3:0] xm, input logic [3:0] ym,
                            input logic [31:0] k);
        CompXMsk = xm; CompYMsk = ym;
        sbQ.push_back(k);
        #2;
        chk(tag, 32'(CompData), sbQ.pop_front());
        step();
    endtask

    task automatic readFlush(input string tag, input logic [3:0] xm, input logic [3:0] ym);
        logic [31:0] e;
        FlushXMsk = xm; FlushYMsk = ym;
        e = modelSel(xm, ym);
        sbQ.push_back(32'(e[7:0]));
        #2;
        chk(tag, 32'(FlushData), sbQ.pop_front());
        step();
    endtask

    task automatic readFlags(input string tag);
        sbQ.push_back(32'(modelEnough()));
        sbQ.push_back(32'(mExec));
        #2;
        chk({tag, "_enough"}, 32'(BlkIsEnough), sbQ.pop_front());
        chk({tag, "_exec"}, 32'(BlkIsExec), sbQ.pop_front());
        step();
    endtask

    initial begin
        idle();
        Reset = 1; ImgWidth = 10'd8; ImgHeight = 10'd8; BlkSz = 16'd4;
        PxlX = 0; PxlY = 0; PxlData = 0; CeData = 0;
        CompXMsk = 0; CompYMsk = 0; CeXMsk = 0; CeYMsk = 0; FlushXMsk = 0; FlushYMsk = 0;
        step(); step();
        Reset = 0;

        // Reset state
        readFlags("rst");
        readCmpK("rst_comp", 4'hF, 4'hF, 0);
        readFlush("rst_flush", 4'hF, 4'hF);

        // 8x8 image: bounds 0,2,4,6,8; pixel x=3,y=1 lands in block (0,1)
        pixel(3, 1, 10);
        readCmpK("w8_blk01", 4'b0010, 4'b0001, 10);
        for (int i = 0; i < 16; i++)
            readCmp($sformatf("w8_blk%0d", i), 4'(1 << (i % 4)), 4'(1 << (i / 4)));
        readCmpK("zero_mask", 4'b0000, 4'b1111, 0);

        // Boundary pixels and out-of-image pixels
        pixel(1, 0, 1); pixel(2, 0, 2); pixel(7, 7, 4); pixel(8, 0, 50); pixel(0, 8, 50);
        readCmpK("x1_col0", 4'b0001, 4'b0001, 1);
        readCmpK("x2_col1", 4'b0010, 4'b0001, 12);
        readCmpK("x7y7_col3", 4'b1000, 4'b1000, 4);
        readCmp("or_all", 4'hF, 4'hF);

        // Block count reaches BlkSz, then CompEn clears the counter only
        doReset();
        pixel(0, 0, 5); pixel(1, 0, 6); pixel(0, 1, 7);
        readFlags("three_px");
        pixel(1, 1, 8);
        chk("enough_b0", 32'(BlkIsEnough[0]), 1);
        readFlags("four_px");
        readCmpK("sum26", 4'b0001, 4'b0001, 26);
        CompXMsk = 4'b0001; CompYMsk = 4'b0001; CompEn = 1;
        step();
        CompEn = 0;
        chk("enough_clr", 32'(BlkIsEnough[0]), 0);
        readCmpK("sum_kept", 4'b0001, 4'b0001, 26);

        // Write-back beats a same-cycle pixel; flush reads then clears exec
        PxlX = 6; PxlY = 4; PxlData = 8'h11; PxlVld = 1;
        CeData = 8'h3C; CeXMsk = 4'b1000; CeYMsk = 4'b0100; CeVld = 1;
        step();
        idle();
        readCmpK("ce_wins", 4'b1000, 4'b0100, 32'h3C);
        chk("exec_b11_set", 32'(BlkIsExec[11]), 1);
        readFlags("after_ce");
        FlushXMsk = 4'b1000; FlushYMsk = 4'b0100; FlushVld = 1;
        #2;
        chk("flush_data", 32'(FlushData), 32'h3C);
        step();
        FlushVld = 0;
        chk("exec_b11_clr", 32'(BlkIsExec[11]), 0);

        // Simultaneous set and clear on one block holds the flag
        CeData = 8'h44; CeXMsk = 4'b0010; CeYMsk = 4'b0010; CeVld = 1;
        FlushXMsk = 4'b0010; FlushYMsk = 4'b0010; FlushVld = 1;
        step();
        chk("hold0", 32'(BlkIsExec[5]), 0);
        FlushVld = 0;
        step();
        chk("set5", 32'(BlkIsExec[5]), 1);
        FlushVld = 1;
        step();
        idle();
        chk("hold1", 32'(BlkIsExec[5]), 1);
        readCmpK("ce_acc5", 4'b0010, 4'b0010, 32'h44);

        // Reset in the middle of accumulation
        pixel(0, 0, 3); pixel(5, 5, 9);
        doReset();
        chk("rst_mid_enough", 32'(BlkIsEnough), 0);
        chk("rst_mid_exec", 32'(BlkIsExec), 0);
        readCmpK("rst_mid_comp", 4'hF, 4'hF, 0);

        // Width 10: bounds 0,2,5,7,10
        ImgWidth = 10'd10; ImgHeight = 10'd10;
        pixel(9, 0, 3);
        readCmpK("w10_x9_col3", 4'b1000, 4'b0001, 3);
        readCmpK("w10_x9_not012", 4'b0111, 4'b0001, 0);
        pixel(4, 3, 20); pixel(5, 3, 40); pixel(7, 3, 1); pixel(10, 3, 99);
        readCmpK("w10_x4_col1", 4'b0010, 4'b0010, 20);
        readCmpK("w10_x5_col2", 4'b0100, 4'b0010, 40);
        readCmpK("w10_x7_col3", 4'b1000, 4'b0010, 1);

        // Random traffic on an odd-sized image with occasional write-back and clear
        doReset();
        ImgWidth = 10'd13; ImgHeight = 10'd7; BlkSz = 16'd2;
        for (int n = 0; n < 80; n++) begin
            PxlX = 10'($urandom_range(0, 14)); PxlY = 10'($urandom_range(0, 8));
            PxlData = 8'($urandom_range(0, 255)); PxlVld = 1'($urandom_range(0, 3) != 0);
            CeVld = 1'($urandom_range(0, 7) == 0); CeData = 8'($urandom_range(0, 255));
            CeXMsk = 4'(1 << $urandom_range(0, 3)); CeYMsk = 4'(1 << $urandom_range(0, 3));
            CompEn = 1'($urandom_range(0, 7) == 0);
            CompXMsk = 4'(1 << $urandom_range(0, 3)); CompYMsk = 4'(1 << $urandom_range(0, 3));
            FlushVld = 1'($urandom_range(0, 7) == 0);
            FlushXMsk = 4'(1 << $urandom_range(0, 3)); FlushYMsk = 4'(1 << $urandom_range(0, 3));
            step();
        end
        idle();
        for (int i = 0; i < 16; i++)
            readCmp($sformatf("rnd_blk%0d", i), 4'(1 << (i % 4)), 4'(1 << (i / 4)));
        readFlush("rnd_flush_all", 4'hF, 4'hF);
        readFlags("rnd");

        // Pooling mode: sum or max of 9,200,17
        doReset();
        ImgWidth = 10'd8; ImgHeight = 10'd8;
        pixel(0, 0, 9); pixel(1, 1, 200); pixel(0, 1, 17);
`ifdef RSZ_MAX_POOL_EN
        readCmpK("pool_max", 4'b0001, 4'b0001, 200);
`else
        readCmpK("pool_sum", 4'b0001, 4'b0001, 226);
`endif
        readFlush("pool_flush", 4'b0001, 4'b0001);

        $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
        $finish;
    end

endmodule

// File: doc/rsz_blk_accum.md
RSZ_BLK_ACCUM -- requirements
Module: rsz_blk_accum

Interface
REQ-001 SHALL have parameter IDX_W, default 10: pixel X/Y index and image-dimension width.
REQ-002 SHALL have parameter RSZ_W, default 4: resized width in blocks; SHALL be a power of 2, log2 = RSZ_WL.
REQ-003 SHALL have parameter RSZ_H, default 4: resized height in blocks; SHALL be a power of 2, log2 = RSZ_HL.
REQ-004 SHALL have parameter PXL_W, default 8: pixel width.
REQ-005 SHALL have parameter SUM_W, default 24: block accumulator width.
REQ-006 SHALL have parameter CNT_W, default 16: block pixel-counter width.
REQ-007 SHALL have port Clk, in, 1: clock, all state on rising edge.
REQ-008 SHALL have port Reset, in, 1: synchronous, active-high reset.
REQ-009 SHALL have ports ImgWidth and ImgHeight, in, IDX_W each: original image size X, Y.
REQ-010 SHALL have ports PxlData (in, PXL_W), PxlX and PxlY (in, IDX_W each) and PxlVld (in, 1): incoming pixel.
REQ-011 SHALL have port BlkSz, in, CNT_W: pixels per block.
REQ-012 SHALL have port BlkIsEnough, out, RSZ_H*RSZ_W: bit y*RSZ_W+x set when block (y,x) is complete.
REQ-013 SHALL have ports CompXMsk (in, RSZ_W), CompYMsk (in, RSZ_H) and CompEn (in, 1): one-hot compute selection and counter clear.
REQ-014 SHALL have port CompData, out, SUM_W: selected block accumulator.
REQ-015 SHALL have ports CeData (in, PXL_W), CeXMsk (in, RSZ_W), CeYMsk (in, RSZ_H) and CeVld (in, 1): compute-engine result write-back.
REQ-016 SHALL have port BlkIsExec, out, RSZ_H*RSZ_W: per-block executed flag.
REQ-017 SHALL have ports FlushXMsk (in, RSZ_W), FlushYMsk (in, RSZ_H) and FlushVld (in, 1): one-hot flush selection.
REQ-018 SHALL have port FlushData, out, PXL_W: low PXL_W bits of the flush-selected accumulator.

Function
REQ-019 SHALL compute the sequence S[u] = u*ImgWidth for u = 0..RSZ_W by successive addition, S[u] = S[u-1] + ImgWidth, with no multipliers; same for ImgHeight over v = 0..RSZ_H.
REQ-020 SHALL compute block bounds BaseX[u] = S[u] >> RSZ_WL and BaseY[v] = T[v] >> RSZ_HL, where T is the ImgHeight sequence.
REQ-021 SHALL place a pixel in column u when BaseX[u] <= PxlX < BaseX[u+1], and in row v likewise; bounds are half-open so every pixel maps to exactly one block.
REQ-022 SHALL add PxlData (zero-extended) to Acc[v][u] on a PxlVld hit, wrapping modulo 2^SUM_W.
REQ-023 SHALL load Acc[y][x] with zero-extended CeData when CeVld & CeXMsk[x] & CeYMsk[y]; on a simultaneous pixel hit, the CeData load wins.
REQ-024 SHALL increment Cnt[y][x] on a pixel hit and clear it on CompEn & CompXMsk[x] & CompYMsk[y]; clear wins on a simultaneous hit.
REQ-025 SHALL drive BlkIsEnough[y][x] combinationally as (Cnt == BlkSz).
REQ-026 SHALL set BlkIsExec[y][x] on a CeVld hit and clear it on a FlushVld hit; when both hit the same block, it holds.
REQ-027 SHALL form CompData and FlushData as the OR of Acc entries whose X-mask and Y-mask bits are both set; an all-zero mask gives 0.
REQ-028 SHALL always accept pixels (no backpressure); all outputs except the registered flags are combinational.

Reset
REQ-029 SHALL clear every Acc, Cnt and BlkIsExec on Reset, so BlkIsEnough = 0 (for BlkSz != 0), CompData = 0 and FlushData = 0.

Configuration
REQ-030 SHALL, when RSZ_MAX_POOL_EN is defined, replace the REQ-022 addition with Acc <= max(Acc, PxlData); without the macro, the block sums (average pooling).

Structure
REQ-031 SHALL place IDX_W, PXL_W, SUM_W, CNT_W defaults and the accumulator typedef in a shared package rsz_pkg.
REQ-032 SHALL implement the OR-based 2-D one-hot selector as sub-module onehot_mux_2d, instantiated twice; the multiply sequence stays inline.

Verification (default parameters unless stated)
REQ-033 SHALL check: ImgWidth=8, ImgHeight=8 -> BaseX = 0,2,4,6,8; pixel (x=3, y=1, data=10) -> Acc[0][1] = 10, all other blocks 0.
REQ-034 SHALL check: BlkSz=4, four pixels 5,6,7,8 into block (0,0) -> BlkIsEnough bit 0 = 1, CompData = 26 with masks 0001/0001; then CompEn -> bit 0 = 0 next cycle.
REQ-035 SHALL check: CeVld with CeData=0x3C on block (2,3) in the same cycle as a pixel hit there -> Acc = 0x3C, BlkIsExec bit 11 = 1; FlushVld on (2,3) -> FlushData = 0x3C, then flag cleared.
REQ-036 SHALL check: Reset asserted mid-accumulation -> next cycle all flags 0 and CompData 0.
REQ-037 SHALL check: with RSZ_MAX_POOL_EN, pixels 9,200,17 into one block -> Acc = 200.
REQ-038 SHALL check: ImgWidth=10 (non-divisible) -> BaseX = 0,2,5,7,10; x=9 lands only in column 3.
